// File: rtl/data_mem_ws.sv
// Wait-state data memory: request/ack load/store port with byte/half/word lanes,
// alignment and range checking, and a programmable completion delay.
module data_mem_ws #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT        = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        stall_o
);

  localparam int          IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          AW     = IDX_W + 2;
  localparam logic [31:0] BYTES  = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic          sign_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          ack_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          req_err;
  logic          access_now;
  logic [AW-1:0] acc_addr;
  logic          acc_we;
  logic          acc_sign;
  logic [1:0]    acc_size;
  logic [31:0]   acc_wdata;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]   cur_word;
  logic [15:0]   sh16;
  logic [31:0]   load_val;
  logic [31:0]   wrep;
  logic [3:0]    be;
  logic [31:0]   store_word;

  always_comb begin
    req_err = (size_i == 2'b11)
            | ((size_i == 2'b01) & addr_i[0])
            | ((size_i == 2'b10) & (addr_i[1:0] != 2'b00))
            | (addr_i >= BYTES);

    // With WAIT=0 the access happens on the acceptance edge, so operands come
    // straight from the ports; otherwise from the latched request.
    if (state_q == IDLE) begin
      acc_addr  = addr_i[AW-1:0];
      acc_we    = we_i;
      acc_sign  = sign_i;
      acc_size  = size_i;
      acc_wdata = wdata_i;
    end else begin
      acc_addr  = addr_q;
      acc_we    = we_q;
      acc_sign  = sign_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
    end

    access_now = ((state_q == IDLE) & req_i & ~req_err & (WAIT_C == 4'd0))
               | ((state_q == BUSY) & (cnt_q == 4'd1));

    acc_idx  = acc_addr[AW-1:2];
    cur_word = mem_q[acc_idx];
    sh16     = 16'(cur_word >> {acc_addr[1:0], 3'b000});

    case (acc_size)
      2'b00:   load_val = acc_sign ? {{24{sh16[7]}}, sh16[7:0]} : {24'h0, sh16[7:0]};
      2'b01:   load_val = acc_sign ? {{16{sh16[15]}}, sh16} : {16'h0, sh16};
      default: load_val = cur_word;
    endcase

    case (acc_size)
      2'b00: begin
        be   = 4'b0001 << acc_addr[1:0];
        wrep = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{acc_wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = acc_wdata;
      end
    endcase

    store_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) store_word[8*i +: 8] = wrep[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;

      if (access_now) begin
        if (acc_we) mem_q[acc_idx] <= store_word;
        else        rdata_q        <= load_val;
      end

      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i[AW-1:0];
            we_q    <= we_i;
            sign_q  <= sign_i;
            size_q  <= size_i;
            wdata_q <= wdata_i;
            if (req_err) begin
              state_q <= RESP;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else if (WAIT_C == 4'd0) begin
              state_q <= RESP;
              ack_q   <= 1'b1;
            end else begin
              state_q <= BUSY;
              cnt_q   <= WAIT_C;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            ack_q   <= 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q != IDLE);
  assign stall_o = req_i & ~ack_q;

endmodule

// File: tb/tb_data_mem_ws.sv
// Scoreboard bench for data_mem_ws: one instance with WAIT=2, one with WAIT=0.
module tb_data_mem_ws;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_s   [2];
  logic        we_s    [2];
  logic        sign_s  [2];
  logic [1:0]  size_s  [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        ack_s   [2];
  logic        err_s   [2];
  logic        busy_s  [2];
  logic        stall_s [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          ack_cyc;
    logic [31:0] rd;
    logic        err;
    bit          chk_rd;
    string       nm;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ws #(.DEPTH_WORDS(128), .WAIT(2)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_s[0]), .we_i(we_s[0]), .size_i(size_s[0]),
    .sign_i(sign_s[0]), .addr_i(addr_s[0]), .wdata_i(wdata_s[0]), .rdata_o(rdata_s[0]),
    .ack_o(ack_s[0]), .err_o(err_s[0]), .busy_o(busy_s[0]), .stall_o(stall_s[0])
  );

  data_mem_ws #(.DEPTH_WORDS(128), .WAIT(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_s[1]), .we_i(we_s[1]), .size_i(size_s[1]),
    .sign_i(sign_s[1]), .addr_i(addr_s[1]), .wdata_i(wdata_s[1]), .rdata_o(rdata_s[1]),
    .ack_o(ack_s[1]), .err_o(err_s[1]), .busy_o(busy_s[1]), .stall_o(stall_s[1])
  );

  function automatic int wait_of(input int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic push(input int sel, input int ack_cyc, input logic [31:0] rd,
                      input logic err, input bit chk_rd, input string nm);
    exp_t e;
    e.ack_cyc = ack_cyc; e.rd = rd; e.err = err; e.chk_rd = chk_rd; e.nm = nm;
    if (sel == 0) sb0.push_back(e);
    else          sb1.push_back(e);
  endtask

  task automatic mon(input int sel);
    exp_t e;
    if (ack_s[sel]) begin
      if ((sel == 0 && sb0.size() == 0) || (sel == 1 && sb1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack dut%0d: got ack at cycle %0d, required none", sel, cyc);
      end else begin
        if (sel == 0) e = sb0.pop_front();
        else          e = sb1.pop_front();
        chk({e.nm, "_latency"}, 32'(cyc), 32'(e.ack_cyc));
        chk({e.nm, "_err"}, {31'h0, err_s[sel]}, {31'h0, e.err});
        if (e.chk_rd) chk({e.nm, "_rdata"}, rdata_s[sel], e.rd);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic drive(input int sel, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    req_s[sel] = 1'b1; we_s[sel] = w; size_s[sel] = sz; sign_s[sel] = sg;
    addr_s[sel] = a; wdata_s[sel] = d;
  endtask

  task automatic wait_ack(input int sel, input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack_s[sel]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({nm, "_ack_arrived"}, 32'd0, 32'd1);
  endtask

  // One full access; also counts stall cycles from acceptance to ack.
  task automatic do_access(input int sel, input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic exp_err, input string nm);
    int  scnt;
    bit  got = 1'b0;
    @(negedge clk);
    drive(sel, w, sz, sg, a, d);
    push(sel, cyc + 1 + (exp_err ? 0 : wait_of(sel)), exp_rd, exp_err, !w || exp_err, nm);
    #1;
    scnt = stall_s[sel] ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack_s[sel]) begin
        got = 1'b1;
        break;
      end
      if (stall_s[sel]) scnt++;
    end
    if (!got) chk({nm, "_ack_arrived"}, 32'd0, 32'd1);
    else      chk({nm, "_stall_cycles"}, 32'(scnt), 32'(exp_err ? 1 : wait_of(sel) + 1));
    req_s[sel] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_s[s] = 1'b0; we_s[s] = 1'b0; sign_s[s] = 1'b0; size_s[s] = 2'b00;
      addr_s[s] = 32'h0; wdata_s[s] = 32'h0;
    end
    repeat (3) @(negedge clk);
    chk("reset_dut2", {rdata_s[0][28:0], ack_s[0], err_s[0], busy_s[0]}, 32'h0);
    chk("reset_dut0", {rdata_s[1][28:0], ack_s[1], err_s[1], busy_s[1]}, 32'h0);
    rst_n = 1'b1;

    // Word round-trip and sub-word merge/extension (WAIT=2)
    do_access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, "st_word_10");
    do_access(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, "ld_word_10");
    do_access(0, 1, 2'b00, 0, 32'h13, 32'h00000080, 32'h0,        0, "st_byte_13");
    do_access(0, 0, 2'b00, 1, 32'h13, 32'h0,        32'hFFFFFF80, 0, "ld_sbyte_13");
    do_access(0, 0, 2'b00, 0, 32'h13, 32'h0,        32'h00000080, 0, "ld_ubyte_13");
    do_access(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'h80ADBEEF, 0, "ld_word_merged");
    do_access(0, 0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFF80AD, 0, "ld_shalf_12");
    do_access(0, 1, 2'b01, 0, 32'h16, 32'h1234ABCD, 32'h0,        0, "st_half_16");
    do_access(0, 0, 2'b10, 0, 32'h14, 32'h0,        32'hABCD0000, 0, "ld_word_14");

    // Error cases: misaligned, out of range, illegal size
    do_access(0, 0, 2'b10, 0, 32'h06,  32'h0,        32'h0, 1, "err_misaligned");
    do_access(0, 1, 2'b10, 0, 32'h200, 32'h55555555, 32'h0, 1, "err_range_store");
    do_access(0, 0, 2'b01, 0, 32'h11,  32'h0,        32'h0, 1, "err_half_odd");
    do_access(0, 0, 2'b11, 0, 32'h08,  32'h0,        32'h0, 1, "err_size11");
    do_access(0, 0, 2'b10, 0, 32'h00,  32'h0,        32'h0, 0, "ld_word_00_untouched");
    do_access(0, 0, 2'b10, 0, 32'h10,  32'h0,        32'h80ADBEEF, 0, "ld_word_10_untouched");

    // Input churn during BUSY: latched store must complete unchanged
    @(negedge clk);
    drive(0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D);
    push(0, cyc + 1 + 2, 32'h0, 0, 0, "st_churn");
    @(negedge clk);
    drive(0, 1, 2'b10, 0, 32'h44, 32'h0BADBAD0);
    req_s[0] = 1'b0;
    wait_ack(0, "st_churn");
    do_access(0, 0, 2'b10, 0, 32'h44, 32'h0, 32'h00000000, 0, "ld_churn_44");
    do_access(0, 0, 2'b10, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0, "ld_churn_40");

    // Reset while a store is in BUSY
    @(negedge clk);
    drive(0, 1, 2'b10, 0, 32'h20, 32'h12345678);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_outputs", {rdata_s[0][28:0], ack_s[0], err_s[0], busy_s[0]}, 32'h0);
    chk("rst_busy_rdata_hi", {29'h0, rdata_s[0][31:29]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    we_s[0] = 1'b0;
    push(0, cyc + 1 + 2, 32'h0, 0, 1, "ld_after_rst_20");
    wait_ack(0, "ld_after_rst_20");
    req_s[0] = 1'b0;
    do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, "ld_after_rst_10");

    // WAIT=0 back-to-back stores with req held high
    @(negedge clk);
    drive(1, 1, 2'b10, 0, 32'h0, 32'h11111111);
    push(1, cyc + 1, 32'h0, 0, 0, "b2b_st0");
    for (int i = 0; i < 4; i++) begin
      wait_ack(1, "b2b");
      chk("b2b_stall_ack", {31'h0, stall_s[1]}, 32'h0);
      if (i < 3) begin
        drive(1, 1, 2'b10, 0, 32'(4 * (i + 1)), 32'h11111111 * 32'(i + 2));
        push(1, cyc + 2, 32'h0, 0, 0, $sformatf("b2b_st%0d", i + 1));
        @(negedge clk);
        chk("b2b_stall_idle", {31'h0, stall_s[1]}, 32'h1);
      end else begin
        req_s[1] = 1'b0;
      end
    end
    do_access(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h11111111, 0, "b2b_ld0");
    do_access(1, 0, 2'b10, 0, 32'h4, 32'h0, 32'h22222222, 0, "b2b_ld1");
    do_access(1, 0, 2'b10, 0, 32'h8, 32'h0, 32'h33333333, 0, "b2b_ld2");
    do_access(1, 0, 2'b10, 0, 32'hC, 32'h0, 32'h44444444, 0, "b2b_ld3");
    do_access(1, 0, 2'b00, 1, 32'hE, 32'h0, 32'h00000044, 0, "b2b_ld_sbyte");
    do_access(1, 1, 2'b10, 0, 32'h3FD, 32'h0, 32'h0, 1, "b2b_err_range");

    repeat (3) @(negedge clk);
    chk("sb_drained_dut2", 32'(sb0.size()), 32'd0);
    chk("sb_drained_dut0", 32'(sb1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
